// File: rtl/pdm_mic_emu.sv
// PDM MEMS-microphone emulator: PCM samples in through a small FIFO, 1-bit PDM out
// from a 2nd-order sigma-delta loop clocked by the host's mic clock.
module pdm_mic_emu #(
    parameter int C_OSR     = 64,
    parameter int C_CH_SEL  = 0,
    parameter int C_CLAMP   = 1536,
    parameter int C_FIFO_AW = 2
) (
    input  logic                   CK_i,
    input  logic                   XARST_i,
    input  logic                   MIC_CK_i,
    input  logic signed [11:0]     PCM_DATs_i,
    input  logic                   PCM_VLD_i,
    output logic                   PCM_RDY_o,
    output logic                   MIC_DAT_o,
    output logic                   UNDF_o,
    output logic [C_FIFO_AW:0]     FIFO_CNTs_o
);

    localparam int C_DEPTH = 2 ** C_FIFO_AW;
    localparam int C_OSR_W = $clog2(C_OSR);

    localparam logic signed [11:0] C_CLAMP_P = 12'(C_CLAMP);
    localparam logic signed [11:0] C_CLAMP_N = -12'(C_CLAMP);
    localparam logic signed [14:0] C_I1_MAX  = 15'h3FFF;
    localparam logic signed [14:0] C_I1_MIN  = 15'h4000;
    localparam logic signed [18:0] C_I2_MAX  = 19'h3FFFF;
    localparam logic signed [18:0] C_I2_MIN  = 19'h40000;

    logic                       r_s1, r_s2, r_s3;
    logic                       w_rise, w_fall, w_ev;

    logic signed [11:0]         r_mem [C_DEPTH];
    logic [C_FIFO_AW-1:0]       r_wrPtr, r_rdPtr;
    logic [C_FIFO_AW:0]         r_cnt, w_cntNext;
    logic                       r_rdy;
    logic                       w_push, w_pop, w_wrap;

    logic [C_OSR_W-1:0]         r_osr;
    logic signed [11:0]         r_x, w_xc;
    logic                       r_undf;

    logic signed [14:0]         r_i1, w_i1New;
    logic signed [18:0]         r_i2, w_i2New;
    logic signed [20:0]         w_fb, w_i1Sum, w_i2Sum;
    logic                       r_dat;

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= MIC_CK_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_ev   = (C_CH_SEL == 0) ? w_rise : w_fall;

    assign w_wrap = w_ev && (r_osr == C_OSR_W'(C_OSR - 1));
    assign w_push = PCM_VLD_i & r_rdy;
    // The pop looks at the occupancy before this cycle's push, so an empty FIFO underflows.
    assign w_pop  = w_wrap && (r_cnt != '0);

    always_comb begin
        w_cntNext = r_cnt;
        if (w_push && !w_pop) begin
            w_cntNext = r_cnt + (C_FIFO_AW + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_cntNext = r_cnt - (C_FIFO_AW + 1)'(1);
        end
    end

    always_ff @(posedge CK_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= PCM_DATs_i;
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
            r_osr   <= '0;
            r_x     <= '0;
            r_undf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + C_FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + C_FIFO_AW'(1);
                r_x     <= r_mem[r_rdPtr];
            end
            if (w_wrap && (r_cnt == '0)) begin
                r_undf <= 1'b1;
            end
            if (w_ev) begin
                r_osr <= w_wrap ? '0 : r_osr + C_OSR_W'(1);
            end
            r_cnt <= w_cntNext;
            r_rdy <= (w_cntNext != (C_FIFO_AW + 1)'(C_DEPTH));
        end
    end

    always_comb begin
        w_xc = r_x;
        if (r_x > C_CLAMP_P) begin
            w_xc = C_CLAMP_P;
        end else if (r_x < C_CLAMP_N) begin
            w_xc = C_CLAMP_N;
        end
    end

    // Sums are formed 21 bits wide so both saturation checks see the true value.
    always_comb begin
        w_fb    = r_dat ? 21'sd2048 : -21'sd2048;
        w_i1Sum = 21'(r_i1) + 21'(w_xc) - w_fb;
        w_i1New = w_i1Sum[14:0];
        if (w_i1Sum > 21'(C_I1_MAX)) begin
            w_i1New = C_I1_MAX;
        end else if (w_i1Sum < 21'(C_I1_MIN)) begin
            w_i1New = C_I1_MIN;
        end
        w_i2Sum = 21'(r_i2) + 21'(w_i1New) - w_fb;
        w_i2New = w_i2Sum[18:0];
        if (w_i2Sum > 21'(C_I2_MAX)) begin
            w_i2New = C_I2_MAX;
        end else if (w_i2Sum < 21'(C_I2_MIN)) begin
            w_i2New = C_I2_MIN;
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_dat <= 1'b0;
        end else if (w_ev) begin
            r_i1  <= w_i1New;
            r_i2  <= w_i2New;
            r_dat <= ~w_i2New[18];
        end
    end

    assign PCM_RDY_o   = r_rdy;
    assign MIC_DAT_o   = r_dat;
    assign UNDF_o      = r_undf;
    assign FIFO_CNTs_o = r_cnt;

endmodule

// File: tb/tb_pdm_mic_emu.sv
// Directed self-checking bench for pdm_mic_emu: reset, handshake, latency on both
// channel edges, ones-density for several DC levels, clamp and underflow.
module tb_pdm_mic_emu;

   logic clock;
   logic rstN;
   logic micRun, micGen, micManual, micCk;
   logic signed [11:0] pcmDat;
   logic pcmVld;
   logic rdyA, datA, undfA;
   logic [2:0] cntA;
   logic rdyB, datB, undfB;
   logic [2:0] cntB;

   int testsRun;
   int testsFailed;
   int bitCount;
   int onesCount;

   assign micCk = micRun ? micGen : micManual;

   pdm_mic_emu #(.C_OSR(64), .C_CH_SEL(0), .C_CLAMP(1536), .C_FIFO_AW(2)) dutLeft (
      .CK_i(clock), .XARST_i(rstN), .MIC_CK_i(micCk),
      .PCM_DATs_i(pcmDat), .PCM_VLD_i(pcmVld), .PCM_RDY_o(rdyA),
      .MIC_DAT_o(datA), .UNDF_o(undfA), .FIFO_CNTs_o(cntA)
   );

   pdm_mic_emu #(.C_OSR(64), .C_CH_SEL(1), .C_CLAMP(1536), .C_FIFO_AW(2)) dutRight (
      .CK_i(clock), .XARST_i(rstN), .MIC_CK_i(micCk),
      .PCM_DATs_i(pcmDat), .PCM_VLD_i(pcmVld), .PCM_RDY_o(rdyB),
      .MIC_DAT_o(datB), .UNDF_o(undfB), .FIFO_CNTs_o(cntB)
   );

   // System clock: 20 ns period stands in for the 48 MHz CK_i.
   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   // Host model: mic clock of 8 system clocks; it samples the left-channel bit on each falling edge.
   initial begin
      int phase;
      phase = 0;
      micGen = 1'b0;
      bitCount = 0;
      onesCount = 0;
      forever begin
         @(negedge clock);
         if (micRun) begin
            if (phase == 0) begin
               micGen = 1'b1;
            end else if (phase == 4) begin
               micGen = 1'b0;
               bitCount = bitCount + 1;
               onesCount = onesCount + int'(datA);
            end
            phase = (phase + 1) % 8;
         end else begin
            phase = 0;
            micGen = 1'b0;
         end
      end
   end

   // Counts one comparison; observed must lie within expected +/- tol.
   task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
      testsRun = testsRun + 1;
      if (observed < expected - tol || observed > expected + tol) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)", tag, observed, expected, tol);
      end
   endtask

   task automatic applyReset();
      micRun = 1'b0;
      micManual = 1'b0;
      pcmVld = 1'b0;
      pcmDat = '0;
      @(negedge clock);
      rstN = 1'b0;
      repeat (3) @(negedge clock);
      rstN = 1'b1;
      @(negedge clock);
   endtask

   // Runs until the host has sampled nBits more bits, optionally keeping the FIFO topped up.
   task automatic applyStimulus(input int nBits, input bit feed, input logic signed [11:0] value);
      int target;
      int guard;
      target = bitCount + nBits;
      guard = 0;
      while (bitCount < target && guard < nBits * 8 + 64) begin
         @(negedge clock);
         #1;
         pcmDat = value;
         pcmVld = feed & rdyA;
         guard = guard + 1;
      end
      pcmVld = 1'b0;
      if (bitCount < target) begin
         checkOutput("bitTimeout", bitCount, target, 0);
      end
   endtask

   task automatic densityTest(input string tag, input logic signed [11:0] value, input int expOnes);
      int ones0;
      applyReset();
      micRun = 1'b1;
      applyStimulus(128, 1'b1, value);
      ones0 = onesCount;
      applyStimulus(1024, 1'b1, value);
      checkOutput(tag, onesCount - ones0, expOnes, 4);
      checkOutput({tag, "Undf"}, undfA, 0, 0);
   endtask

   initial begin
      int prevWin;
      int curWin;
      int maxDiff;
      int ones0;
      int total;
      int guard;

      testsRun = 0;
      testsFailed = 0;
      rstN = 1'b1;
      micRun = 1'b0;
      micManual = 1'b0;
      pcmVld = 1'b0;
      pcmDat = '0;

      applyReset();
      checkOutput("resetRdy", rdyA, 1, 0);
      checkOutput("resetDat", datA, 0, 0);
      checkOutput("resetUndf", undfA, 0, 0);
      checkOutput("resetCnt", cntA, 0, 0);

      // Reset mid-stream with three samples queued and the data line high.
      micRun = 1'b1;
      applyStimulus(20, 1'b0, 12'sd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         pcmDat = 12'sd300;
         pcmVld = 1'b1;
      end
      @(negedge clock);
      #1;
      pcmVld = 1'b0;
      checkOutput("midCnt", cntA, 3, 0);
      guard = 0;
      while (datA !== 1'b1 && guard < 100) begin
         @(negedge clock);
         #1;
         guard = guard + 1;
      end
      checkOutput("midDatHigh", datA, 1, 0);
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("midRstRdy", rdyA, 1, 0);
      checkOutput("midRstDat", datA, 0, 0);
      checkOutput("midRstUndf", undfA, 0, 0);
      checkOutput("midRstCnt", cntA, 0, 0);
      @(negedge clock);
      rstN = 1'b1;

      // First EV from all-zero state: I1=2048, I2=4096, so the bit becomes 1.
      applyReset();
      @(negedge clock);
      micManual = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("latL1", datA, 0, 0);
      @(posedge clock);
      #1;
      checkOutput("latL2", datA, 0, 0);
      @(posedge clock);
      #1;
      checkOutput("latL3", datA, 1, 0);
      checkOutput("latRNoRise", datB, 0, 0);
      @(negedge clock);
      micManual = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("latR2", datB, 0, 0);
      @(posedge clock);
      #1;
      checkOutput("latR3", datB, 1, 0);
      checkOutput("latLHold", datA, 1, 0);

      // Handshake: VLD held high for 6 cycles with the mic clock stopped.
      applyReset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         #1;
         checkOutput($sformatf("hsRdy%0d", i), rdyA, (i < 4) ? 1 : 0, 0);
         pcmDat = 12'(100 + i);
         pcmVld = 1'b1;
      end
      @(negedge clock);
      #1;
      pcmVld = 1'b0;
      checkOutput("hsCntFull", cntA, 4, 0);
      checkOutput("hsRdyFull", rdyA, 0, 0);
      micRun = 1'b1;
      applyStimulus(63, 1'b0, 12'sd0);
      checkOutput("hsCntBeforePop", cntA, 4, 0);
      applyStimulus(1, 1'b0, 12'sd0);
      checkOutput("hsCntAfterPop", cntA, 3, 0);
      checkOutput("hsRdyAfterPop", rdyA, 1, 0);

      // Zero input: 512 ones per 1024 bits, adjacent 64-bit windows within 2 of each other.
      applyReset();
      micRun = 1'b1;
      applyStimulus(128, 1'b1, 12'sd0);
      prevWin = 0;
      maxDiff = 0;
      total = 0;
      for (int w = 0; w < 16; w++) begin
         ones0 = onesCount;
         applyStimulus(64, 1'b1, 12'sd0);
         curWin = onesCount - ones0;
         total = total + curWin;
         if (w > 0 && (curWin - prevWin > maxDiff || prevWin - curWin > maxDiff)) begin
            maxDiff = (curWin > prevWin) ? curWin - prevWin : prevWin - curWin;
         end
         prevWin = curWin;
      end
      checkOutput("zeroOnes", total, 512, 4);
      checkOutput("zeroWinDiff", maxDiff, 1, 1);
      checkOutput("zeroUndf", undfA, 0, 0);

      densityTest("dcPos1024", 12'sd1024, 768);
      densityTest("dcNeg1024", -12'sd1024, 256);
      densityTest("clampPos2047", 12'sd2047, 896);
      densityTest("dcPos1536", 12'sd1536, 896);

      // Underflow: one sample of +512, popped at the first wrap; the second wrap finds it empty.
      applyReset();
      @(negedge clock);
      #1;
      pcmDat = 12'sd512;
      pcmVld = 1'b1;
      @(negedge clock);
      #1;
      pcmVld = 1'b0;
      checkOutput("ufCnt", cntA, 1, 0);
      micRun = 1'b1;
      applyStimulus(64, 1'b0, 12'sd0);
      checkOutput("ufCntPopped", cntA, 0, 0);
      checkOutput("ufUndfWrap1", undfA, 0, 0);
      applyStimulus(63, 1'b0, 12'sd0);
      checkOutput("ufUndfBefore", undfA, 0, 0);
      applyStimulus(1, 1'b0, 12'sd0);
      checkOutput("ufUndfWrap2", undfA, 1, 0);
      applyStimulus(128, 1'b0, 12'sd0);
      ones0 = onesCount;
      applyStimulus(1024, 1'b0, 12'sd0);
      checkOutput("ufOnes", onesCount - ones0, 640, 4);
      checkOutput("ufUndfSticky", undfA, 1, 0);

      micRun = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
